adc_pipe_decimator: RTL and testbench

Downstream consumer of the pipeline ADC encoder output word. Samples the encoded NUM_BITS code on a per-conversion strobe. Discards the first PIPE_LATENCY codes after enable, because the encoder pipeline holds stale or reset data during that time. Sums 2^LOG2_OSR consecutive codes into one wider result and presents it to the readout/digital back-end over a valid/ready handshake with overrun detection.

---
 rtl/adc_pipe_decimator.sv | 104 ++++++++++
 tb/tb_adc_pipe_decimator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pipe_decimator.sv
// adc_pipe_decimator: flushes stale encoder codes after enable, then sums
// 2^LOG2_OSR consecutive codes into one result and hands it to the back-end
// over valid/ready with a sticky overrun flag.
module adc_pipe_decimator #(
  parameter  int unsigned NUM_BITS     = 3,
  parameter  int unsigned LOG2_OSR     = 2,
  parameter  int unsigned PIPE_LATENCY = 2,
  localparam int unsigned SUM_BITS     = NUM_BITS + LOG2_OSR
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                en_i,
  input  logic                sample_i,
  input  logic [NUM_BITS-1:0] d_i,
  output logic [SUM_BITS-1:0] sum_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overrun_o,
  output logic                busy_o
);

  localparam int unsigned FLUSH_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [FLUSH_W-1:0]  FLUSH_LAST =
    FLUSH_W'((PIPE_LATENCY > 0) ? (PIPE_LATENCY - 1) : 0);
  localparam logic [LOG2_OSR-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACCUM = 2'd2
  } state_e;

  state_e              state;
  logic [SUM_BITS-1:0] acc;
  logic [LOG2_OSR-1:0] smp_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;

  logic                complete_c;
  logic [SUM_BITS-1:0] result_c;

  // A result completes on the strobe that fills the last slot of the group
  assign complete_c = en_i && sample_i && (state == ACCUM) && (smp_cnt == CNT_LAST);
  assign result_c   = acc + SUM_BITS'(d_i);

  // Control FSM: flush stale codes, then accumulate groups gap-free
  always_ff @(posedge clk_i) begin
    if (!reset_ni || !en_i) begin
      state     <= IDLE;
      acc       <= '0;
      smp_cnt   <= '0;
      flush_cnt <= '0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acc       <= '0;
          smp_cnt   <= '0;
          flush_cnt <= '0;
          busy_o    <= 1'b1;
          state     <= (PIPE_LATENCY == 0) ? ACCUM : FLUSH;
        end
        FLUSH: begin
          if (sample_i) begin
            if (flush_cnt == FLUSH_LAST) begin
              flush_cnt <= '0;
              state     <= ACCUM;
            end else begin
              flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
          end
        end
        ACCUM: begin
          if (sample_i) begin
            smp_cnt <= smp_cnt + LOG2_OSR'(1);
            acc     <= complete_c ? '0 : result_c;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on completion unless an unconsumed result blocks it
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sum_o     <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (complete_c) begin
      if (!valid_o || ready_i) begin
        sum_o   <= result_c;
        valid_o <= 1'b1;
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_pipe_decimator.sv
// Testbench for adc_pipe_decimator: queue-based reference model compared every
// cycle, plus directed sequences with literal expected values.
module tb_adc_pipe_decimator;

  localparam int unsigned NUM_BITS     = 3;
  localparam int unsigned LOG2_OSR     = 2;
  localparam int unsigned PIPE_LATENCY = 2;
  localparam int unsigned SUM_BITS     = NUM_BITS + LOG2_OSR;
  localparam int          OSR          = 1 << LOG2_OSR;

  logic                clk_i = 1'b0;
  logic                reset_ni;
  logic                en_i;
  logic                sample_i;
  logic [NUM_BITS-1:0] d_i;
  logic [SUM_BITS-1:0] sum_o;
  logic                valid_o;
  logic                ready_i;
  logic                overrun_o;
  logic                busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  adc_pipe_decimator #(
    .NUM_BITS    (NUM_BITS),
    .LOG2_OSR    (LOG2_OSR),
    .PIPE_LATENCY(PIPE_LATENCY)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (en_i),
    .sample_i (sample_i),
    .d_i      (d_i),
    .sum_o    (sum_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enable session, discard budget and a queue of group codes
  int  m_sum     = 0;
  bit  m_valid   = 0;
  bit  m_ovr     = 0;
  bit  m_busy    = 0;
  bit  m_active  = 0;
  int  m_discard = 0;
  int  m_grp[$];
  bit  m_seen    = 0;

  always @(posedge clk_i) begin
    bit done;
    int res;
    done = 0;
    res  = 0;
    m_seen = 1;
    if (!reset_ni) begin
      m_sum = 0; m_valid = 0; m_ovr = 0; m_busy = 0;
      m_active = 0; m_discard = 0; m_grp.delete();
    end else begin
      if (!en_i) begin
        m_active = 0;
        m_grp.delete();
      end else if (!m_active) begin
        m_active  = 1;
        m_discard = PIPE_LATENCY;
        m_grp.delete();
      end else if (sample_i) begin
        if (m_discard > 0) begin
          m_discard--;
        end else begin
          m_grp.push_back(int'(d_i));
          if (m_grp.size() == OSR) begin
            foreach (m_grp[k]) res += m_grp[k];
            done = 1;
            m_grp.delete();
          end
        end
      end
      if (done) begin
        if (!m_valid || ready_i) begin
          m_sum   = res;
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && ready_i) begin
        m_valid = 0;
      end
      m_busy = m_active;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk_i) begin
    if (m_seen) begin
      check("model_valid", int'(valid_o), int'(m_valid));
      check("model_overrun", int'(overrun_o), int'(m_ovr));
      check("model_busy", int'(busy_o), int'(m_busy));
      check("model_sum", int'(sum_o), m_sum);
    end
  end

  task automatic step(input logic en, input logic s, input int d, input logic rdy);
    @(negedge clk_i);
    reset_ni = 1'b1;
    en_i     = en;
    sample_i = s;
    d_i      = NUM_BITS'(d);
    ready_i  = rdy;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      reset_ni = 1'b0;
      en_i     = 1'b1;
      sample_i = 1'b1;
      d_i      = NUM_BITS'(6);
      ready_i  = 1'b0;
    end
  endtask

  task automatic group4(input int a, input int b, input int c, input int d, input logic rdy);
    step(1, 1, a, rdy);
    step(1, 1, b, rdy);
    step(1, 1, c, rdy);
    step(1, 1, d, rdy);
  endtask

  initial begin
    reset_ni = 1'b0;
    en_i     = 1'b1;
    sample_i = 1'b1;
    d_i      = '0;
    ready_i  = 1'b1;

    // Reset with enable and strobes active
    do_reset(2);
    step(1, 0, 0, 1);
    check("rst_sum", int'(sum_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_overrun", int'(overrun_o), 0);
    check("rst_busy", int'(busy_o), 0);

    // Flush 7,1 then sum 3+4+5+6
    step(1, 1, 7, 1);
    check("flush_busy", int'(busy_o), 1);
    step(1, 1, 1, 1);
    group4(3, 4, 5, 6, 1);
    step(1, 0, 0, 1);
    check("basic_sum", int'(sum_o), 18);
    check("basic_valid", int'(valid_o), 1);
    step(1, 0, 0, 1);
    check("basic_consumed", int'(valid_o), 0);
    check("basic_hold", int'(sum_o), 18);

    // Full scale, back to back
    group4(7, 7, 7, 7, 1);
    step(1, 1, 7, 1);
    check("fs_sum1", int'(sum_o), 28);
    check("fs_valid1", int'(valid_o), 1);
    step(1, 1, 7, 1);
    step(1, 1, 7, 1);
    step(1, 1, 7, 1);
    step(1, 0, 0, 1);
    check("fs_sum2", int'(sum_o), 28);
    check("fs_valid2", int'(valid_o), 1);
    check("fs_no_overrun", int'(overrun_o), 0);
    step(1, 0, 0, 1);

    // Overrun: consumer stalled across two results
    group4(1, 1, 1, 1, 0);
    group4(2, 2, 2, 2, 0);
    step(1, 0, 0, 0);
    check("ovr_sum", int'(sum_o), 4);
    check("ovr_valid", int'(valid_o), 1);
    check("ovr_flag", int'(overrun_o), 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("ovr_drained", int'(valid_o), 0);
    check("ovr_sticky", int'(overrun_o), 1);

    // Handshake on the same edge as a completion
    do_reset(2);
    step(1, 0, 0, 0);
    check("rst2_overrun", int'(overrun_o), 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    group4(1, 1, 1, 1, 0);
    step(1, 0, 0, 0);
    check("hs_first_sum", int'(sum_o), 4);
    check("hs_first_valid", int'(valid_o), 1);
    step(1, 1, 2, 0);
    step(1, 1, 2, 0);
    step(1, 1, 2, 0);
    step(1, 1, 2, 1);
    step(1, 0, 0, 1);
    check("hs_sum", int'(sum_o), 8);
    check("hs_valid", int'(valid_o), 1);
    check("hs_no_overrun", int'(overrun_o), 0);
    step(1, 0, 0, 1);

    // Disable mid-group, re-enable, flush again
    step(1, 1, 3, 1);
    step(1, 1, 3, 1);
    step(0, 1, 7, 1);
    step(1, 1, 7, 1);
    check("dis_busy", int'(busy_o), 0);
    step(1, 1, 5, 1);
    check("reen_busy", int'(busy_o), 1);
    step(1, 1, 5, 1);
    group4(1, 2, 3, 4, 1);
    step(1, 0, 0, 1);
    check("dis_sum", int'(sum_o), 10);
    check("dis_valid", int'(valid_o), 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
